// File: rtl/aes444_dom.sv
// aes444_dom: first-order DOM-masked (2-share) small-scale AES SR(10,4,4,4) core.
// 16 state S-boxes plus 4 key-schedule S-boxes run in parallel; one round takes 4 cycles.
module aes444_dom (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [63:0]  key_in,
    input  logic [63:0]  text_in,
    input  logic [63:0]  t_mask,
    input  logic [63:0]  k_mask,
    input  logic [359:0] random_bits,
    output logic [63:0]  text_out
);

    // GF(2^4) multiply, polynomial x^4+x+1
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] acc;
        logic [3:0] sh;
        acc = 4'h0;
        sh  = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[2:0], 1'b0} ^ {2'b00, sh[3], sh[3]};
        end
        return acc;
    endfunction

    function automatic logic [3:0] gf_sq(input logic [3:0] a);
        return gf_mul(a, a);
    endfunction

    // Linear part of the S-box affine map; the 0x6 constant is added on share0 only
    function automatic logic [3:0] affine_lin(input logic [3:0] x);
        return {x[0] ^ x[1] ^ x[3], x[0] ^ x[2] ^ x[3], x[1] ^ x[2] ^ x[3], x[0] ^ x[1] ^ x[2]};
    endfunction

    function automatic logic [63:0] shift_rows(input logic [63:0] v);
        logic [63:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[63-4*(4*c+r) -: 4] = v[63-4*(4*((c+r)%4)+r) -: 4];
            end
        end
        return o;
    endfunction

    function automatic logic [63:0] mix_cols(input logic [63:0] v);
        logic [63:0] o;
        logic [3:0]  a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = v[63-16*c -: 4];
            a1 = v[59-16*c -: 4];
            a2 = v[55-16*c -: 4];
            a3 = v[51-16*c -: 4];
            o[63-16*c -: 4] = gf_mul(4'h2, a0) ^ gf_mul(4'h3, a1) ^ a2 ^ a3;
            o[59-16*c -: 4] = a0 ^ gf_mul(4'h2, a1) ^ gf_mul(4'h3, a2) ^ a3;
            o[55-16*c -: 4] = a0 ^ a1 ^ gf_mul(4'h2, a2) ^ gf_mul(4'h3, a3);
            o[51-16*c -: 4] = gf_mul(4'h3, a0) ^ a1 ^ a2 ^ gf_mul(4'h2, a3);
        end
        return o;
    endfunction

    // Per-share key expansion; sub already carries rcon on share0
    function automatic logic [63:0] key_next(input logic [63:0] k, input logic [15:0] sub);
        logic [63:0] o;
        o[63:48] = k[63:48] ^ sub;
        o[47:32] = k[47:32] ^ o[63:48];
        o[31:16] = k[31:16] ^ o[47:32];
        o[15:0]  = k[15:0]  ^ o[31:16];
        return o;
    endfunction

    function automatic logic [3:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 4'h1;
            4'd2:    return 4'h2;
            4'd3:    return 4'h4;
            4'd4:    return 4'h8;
            4'd5:    return 4'h3;
            4'd6:    return 4'h6;
            4'd7:    return 4'hC;
            4'd8:    return 4'hB;
            4'd9:    return 4'h5;
            4'd10:   return 4'hA;
            default: return 4'h0;
        endcase
    endfunction

    logic [63:0] s0_q, s1_q, k0_q, k1_q, text_out_q;
    logic [63:0] s0_d, s1_d, k0_d, k1_d;
    logic        busy_q;
    logic [3:0]  round_q;
    logic [1:0]  cyc_q;

    // S-box pipeline registers (index 0..15 state, 16..19 key schedule)
    logic [19:0][3:0] p00_q, p11_q, p01_q, p10_q, y0_q, y1_q, q00_q, q11_q, q01_q, q10_q;
    logic [19:0][3:0] p00_d, p11_d, p01_d, p10_d, y0_d, y1_d, q00_d, q11_d, q01_d, q10_d;
    logic [19:0][3:0] sin0, sin1, sq0, sq1, x12_0, x12_1, sb0, sb1;
    logic [19:0][15:0] rnd;
    logic [63:0] sub0, sub1, mc0, mc1;
    logic        unused_rnd;

    // Masked S-box datapath and round function, evaluated every cycle
    always_comb begin
        sub0       = '0;
        sub1       = '0;
        unused_rnd = 1'b0;
        for (int k = 0; k < 20; k++) begin
            rnd[k]     = random_bits[18*k +: 16];
            unused_rnd = unused_rnd ^ random_bits[18*k+16] ^ random_bits[18*k+17];
            if (k < 16) begin
                sin0[k] = s0_q[63-4*k -: 4];
                sin1[k] = s1_q[63-4*k -: 4];
            end else begin
                // RotWord(w3): key S-box j takes cell 12 + (j+1)%4
                sin0[k] = k0_q[63-4*(12+((k-15)%4)) -: 4];
                sin1[k] = k1_q[63-4*(12+((k-15)%4)) -: 4];
            end
            sq0[k]   = gf_sq(sin0[k]);
            sq1[k]   = gf_sq(sin1[k]);
            p00_d[k] = gf_mul(sin0[k], sq0[k]);
            p11_d[k] = gf_mul(sin1[k], sq1[k]);
            p01_d[k] = gf_mul(sin0[k], sq1[k]) ^ rnd[k][3:0];
            p10_d[k] = gf_mul(sin1[k], sq0[k]) ^ rnd[k][3:0];
            y0_d[k]  = sq0[k] ^ rnd[k][7:4];
            y1_d[k]  = sq1[k] ^ rnd[k][7:4];
            x12_0[k] = gf_sq(gf_sq(p00_q[k] ^ p01_q[k]));
            x12_1[k] = gf_sq(gf_sq(p11_q[k] ^ p10_q[k]));
            q00_d[k] = gf_mul(x12_0[k], y0_q[k]);
            q11_d[k] = gf_mul(x12_1[k], y1_q[k]);
            q01_d[k] = gf_mul(x12_0[k], y1_q[k]) ^ rnd[k][11:8];
            q10_d[k] = gf_mul(x12_1[k], y0_q[k]) ^ rnd[k][11:8];
            sb0[k]   = affine_lin(q00_q[k] ^ q01_q[k] ^ rnd[k][15:12]) ^ 4'h6;
            sb1[k]   = affine_lin(q11_q[k] ^ q10_q[k] ^ rnd[k][15:12]);
            if (k < 16) begin
                sub0[63-4*k -: 4] = sb0[k];
                sub1[63-4*k -: 4] = sb1[k];
            end
        end
        k0_d = key_next(k0_q, {sb0[16] ^ rcon(round_q), sb0[17], sb0[18], sb0[19]});
        k1_d = key_next(k1_q, {sb1[16], sb1[17], sb1[18], sb1[19]});
        mc0  = shift_rows(sub0);
        mc1  = shift_rows(sub1);
        if (round_q != 4'd10) begin
            mc0 = mix_cols(mc0);
            mc1 = mix_cols(mc1);
        end
        s0_d = mc0 ^ k0_d;
        s1_d = mc1 ^ k1_d;
    end

    // S-box pipeline stages: mult1/refresh at c=0, mult2 at c=1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p00_q <= '0; p11_q <= '0; p01_q <= '0; p10_q <= '0; y0_q <= '0; y1_q <= '0;
            q00_q <= '0; q11_q <= '0; q01_q <= '0; q10_q <= '0;
        end else if (busy_q && cyc_q == 2'd0) begin
            p00_q <= p00_d; p11_q <= p11_d; p01_q <= p01_d; p10_q <= p10_d;
            y0_q  <= y0_d;  y1_q  <= y1_d;
        end else if (busy_q && cyc_q == 2'd1) begin
            q00_q <= q00_d; q11_q <= q11_d; q01_q <= q01_d; q10_q <= q10_d;
        end
    end

    // Control: start/load, round sequencing, share update at c=2, output at final c=3
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_q <= '0; s1_q <= '0; k0_q <= '0; k1_q <= '0;
            text_out_q <= '0;
            busy_q     <= 1'b0;
            round_q    <= 4'd0;
            cyc_q      <= 2'd0;
        end else if (!busy_q) begin
            if (start) begin
                k0_q    <= key_in ^ k_mask;
                k1_q    <= k_mask;
                s0_q    <= text_in ^ t_mask ^ key_in ^ k_mask;
                s1_q    <= t_mask ^ k_mask;
                busy_q  <= 1'b1;
                round_q <= 4'd1;
                cyc_q   <= 2'd0;
            end
        end else begin
            cyc_q <= cyc_q + 2'd1;
            if (cyc_q == 2'd2) begin
                s0_q <= s0_d; s1_q <= s1_d; k0_q <= k0_d; k1_q <= k1_d;
            end else if (cyc_q == 2'd3) begin
                if (round_q == 4'd10) begin
                    text_out_q <= s0_q ^ s1_q;
                    busy_q     <= 1'b0;
                end else begin
                    round_q <= round_q + 4'd1;
                end
            end
        end
    end

    assign text_out = text_out_q;

endmodule

// File: tb/tb_aes444_dom.sv
// tb_aes444_dom: directed bench for aes444_dom against an unmasked SR(10,4,4,4) model.
module tb_aes444_dom;

    localparam logic [63:0] Key  = 64'hFEDCBA9876543210;
    localparam logic [63:0] TMsk = 64'hcf262e324a00edca;
    localparam logic [63:0] KMsk = 64'h6865498b823f27f8;

    logic         clk, rst, start;
    logic [63:0]  key_in, text_in, t_mask, k_mask, text_out;
    logic [359:0] random_bits;
    logic [359:0] rconst;
    logic [63:0]  last_exp;
    int           rmode;
    int           n_checks, n_errors;

    aes444_dom dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .key_in      (key_in),
        .text_in     (text_in),
        .t_mask      (t_mask),
        .k_mask      (k_mask),
        .random_bits (random_bits),
        .text_out    (text_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [359:0] rand360();
        logic [383:0] t;
        for (int i = 0; i < 12; i++) t[32*i +: 32] = $urandom;
        return t[359:0];
    endfunction

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'h6; 4'h1: return 4'hB; 4'h2: return 4'h5; 4'h3: return 4'h4;
            4'h4: return 4'h2; 4'h5: return 4'hE; 4'h6: return 4'h7; 4'h7: return 4'hA;
            4'h8: return 4'h9; 4'h9: return 4'hD; 4'hA: return 4'hF; 4'hB: return 4'hC;
            4'hC: return 4'h3; 4'hD: return 4'h1; 4'hE: return 4'h0; default: return 4'h8;
        endcase
    endfunction

    function automatic logic [3:0] rc_of(input int r);
        case (r)
            1: return 4'h1; 2: return 4'h2; 3: return 4'h4; 4: return 4'h8; 5: return 4'h3;
            6: return 4'h6; 7: return 4'hC; 8: return 4'hB; 9: return 4'h5; default: return 4'hA;
        endcase
    endfunction

    function automatic logic [3:0] xt(input logic [3:0] a);
        return a[3] ? ({a[2:0], 1'b0} ^ 4'h3) : {a[2:0], 1'b0};
    endfunction

    // Plain table-driven SR(10,4,4,4) encryption
    function automatic logic [63:0] sr_enc(input logic [63:0] key, input logic [63:0] pt);
        logic [3:0]  st[16];
        logic [3:0]  nx[16];
        logic [3:0]  k[16];
        logic [3:0]  t[4];
        logic [3:0]  a0, a1, a2, a3;
        logic [63:0] o;
        for (int i = 0; i < 16; i++) begin
            k[i]  = key[63-4*i -: 4];
            st[i] = pt[63-4*i -: 4] ^ k[i];
        end
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) st[i] = sbox(st[i]);
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) nx[4*c+w] = st[4*((c+w)%4)+w];
            for (int c = 0; c < 4; c++) begin
                a0 = nx[4*c]; a1 = nx[4*c+1]; a2 = nx[4*c+2]; a3 = nx[4*c+3];
                if (r < 10) begin
                    st[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    st[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    st[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    st[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    st[4*c] = a0; st[4*c+1] = a1; st[4*c+2] = a2; st[4*c+3] = a3;
                end
            end
            t[0] = sbox(k[13]) ^ rc_of(r);
            t[1] = sbox(k[14]);
            t[2] = sbox(k[15]);
            t[3] = sbox(k[12]);
            for (int j = 0; j < 4; j++) k[j] = k[j] ^ t[j];
            for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ k[i];
        end
        for (int i = 0; i < 16; i++) o[63-4*i -: 4] = st[i];
        return o;
    endfunction

    // Randomness source: 0 zero, 1 new every 4 cycles, 2 new every cycle, 3 held pattern
    initial begin
        int cnt;
        cnt = 0;
        random_bits = '0;
        forever begin
            @(posedge clk);
            #1;
            cnt++;
            case (rmode)
                0:       random_bits = '0;
                1:       if (cnt % 4 == 0) random_bits = rand360();
                2:       random_bits = rand360();
                default: random_bits = rconst;
            endcase
        end
    end

    // Called 2 time units after a rising edge; start is sampled on the next edge.
    task automatic run_enc(input string tag, input logic [63:0] key, input logic [63:0] pt,
                           input logic [63:0] tm, input logic [63:0] km, input int mode,
                           input int extra_at, input int rst_at);
        logic [63:0] exp;
        exp     = sr_enc(key, pt);
        rmode   = mode;
        key_in  = key;
        text_in = pt;
        t_mask  = tm;
        k_mask  = km;
        start   = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            start = (e == extra_at);
            if (e == extra_at) text_in = ~pt;
            @(posedge clk);
            #2;
            start = 1'b0;
            if (e == rst_at) begin
                rst = 1'b0;
                #1;
                check({tag, "_rst"}, text_out, 64'h0);
                last_exp = 64'h0;
                @(posedge clk);
                #2;
                rst = 1'b1;
                break;
            end
            if (e == 20) check({tag, "_hold20"}, text_out, last_exp);
            if (e == 39) check({tag, "_hold39"}, text_out, last_exp);
            if (e == 40) begin
                check({tag, "_done"}, text_out, exp);
                last_exp = exp;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        last_exp = 64'h0;
        rmode    = 2;
        rconst   = rand360();
        rst      = 1'b0;
        start    = 1'b1;
        key_in   = {$urandom, $urandom};
        text_in  = {$urandom, $urandom};
        t_mask   = {$urandom, $urandom};
        k_mask   = {$urandom, $urandom};
        repeat (3) @(posedge clk);
        #2;
        check("reset_out", text_out, 64'h0);
        @(posedge clk);
        #2;
        check("reset_out2", text_out, 64'h0);
        start = 1'b0;
        rst   = 1'b1;
        repeat (50) @(posedge clk);
        #2;
        check("idle_out", text_out, 64'h0);

        run_enc("golden", Key, 64'h0, TMsk, KMsk, 1, 10, 0);
        run_enc("nomask", Key, 64'h0, 64'h0, 64'h0, 0, 0, 0);
        run_enc("rconst", Key, 64'h0, TMsk, KMsk, 3, 0, 0);
        run_enc("rcycle", Key, 64'h0, TMsk, KMsk, 2, 0, 0);
        run_enc("b2b", Key, 64'h0123456789abcdef, {$urandom, $urandom}, {$urandom, $urandom},
                2, 0, 0);
        run_enc("abort", Key, 64'hdeadbeefcafef00d, TMsk, KMsk, 1, 0, 20);
        repeat (45) @(posedge clk);
        #2;
        check("abort_idle", text_out, 64'h0);
        run_enc("fresh", 64'h0f1e2d3c4b5a6978, 64'h1122334455667788, TMsk, KMsk, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aes444_dom.md
Name: aes444_dom

Overview:
- First-order Domain-Oriented-Masked (DOM, 2 shares) small-scale AES SR(10,4,4,4): 4x4 state of 4-bit cells, 64-bit block and key, 10 rounds, GF(2^4) arithmetic.
- Takes the plaintext/key plus their masks and converts them to shares internally; masks every nonlinear step with fresh randomness.
- Outputs the recombined, unmasked ciphertext.
- Standalone crypto core, used as a side-channel evaluation target.

Parameters:
- none (all widths fixed)

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  begin encryption; sampled on a rising edge while idle
- key_in  input  64  cipher key (unmasked value)
- text_in  input  64  plaintext (unmasked value)
- t_mask  input  64  plaintext mask; share0 = text_in^t_mask, share1 = t_mask
- k_mask  input  64  key mask; share0 = key_in^k_mask, share1 = k_mask
- random_bits  input  360  fresh randomness, consumed every cycle of a round
- text_out  output  64  ciphertext, = state share0 ^ share1 after the final round

Behaviour:
- Nibble order: cell i = bits [63-4i:60-4i]; column-major, so column c = cells 4c..4c+3 and row r = cell index mod 4.
- Field: GF(2^4) with polynomial x^4+x+1.
- S-box is the SR small-scale S-box, table 0..F -> 6,B,5,4,2,E,7,A,9,D,F,C,3,1,0,8.
  - Computed as inversion x^14, then affine; affine constant 0x6 is applied on share0 only.
- ShiftRows: row r rotated left by r cells.
- MixColumns: circulant (2,3,1,1) over GF(2^4); omitted in round 10.
- Key schedule: w_i = w_{i-4} ^ (i%4==0 ? SubWord(RotWord(w_{i-1})) ^ rcon : w_{i-1}).
  - rcon is the nibble in the top cell: 1,2,4,8,3,6,C,B,5,A.
  - Uses 4 masked S-boxes.
- Masked S-box (per instance, 18 random bits r[17:0]):
  - x2 = x^2 per share (linear).
  - Mult1: x3 = x*x2, DOM-indep.
    - z0 = x0*y0 ^ reg(x0*y1 ^ r[3:0]); z1 = x1*y1 ^ reg(x1*y0 ^ r[3:0]).
    - All four products register before the XOR.
  - Refresh the x2 copy with r[7:4], registered (shares ^= r on both).
  - x12 = x3^4 (linear).
  - Mult2: x14 = x12*x2' with r[11:8].
  - Output refresh with r[15:12].
  - r[17:16] unused.
- random_bits allocation:
  - State S-box k (k=0..15) uses bits [18k+17:18k].
  - Key S-box j (j=0..3) uses bits [288+18j+17:288+18j].
- Round schedule: 4 cycles per round, cycle counter c=0..3.
  - c=0: mult1 and refresh registered.
  - c=1: mult2 registered.
  - c=2: output refresh, affine, ShiftRows, MixColumns, new round key, AddRoundKey; state and key share registers written.
  - c=3: idle.
- Start: on a rising edge with start=1 and idle:
  - Load key shares.
  - Load state shares as (text_in^t_mask^key_in^k_mask, t_mask^k_mask), i.e. the initial AddRoundKey is applied.
  - Set busy; round=1, c=0.
- Completion: after round 10, c=2:
  - c=3 registers text_out = share0^share1 and clears busy.
  - text_out is valid exactly 40 rising edges after the start edge.
  - text_out holds until the next completion; it is not cleared when a new start is accepted.
- start while busy is ignored.
- Reset (asynchronous, active-low): state/key shares, counters, busy and text_out all go to 0. Reset mid-operation aborts the encryption; no output is produced.
- Ciphertext is independent of t_mask, k_mask and random_bits values. Masks and randomness change the shares only.
- Shares are never combined except in the text_out XOR.

Test Plan:
- Reset: rst=0 with arbitrary inputs -> text_out=0; after release with start=0 -> text_out stays 0.
- Golden, masked: key_in=FEDCBA9876543210, text_in=0, t_mask=cf262e324a00edca, k_mask=6865498b823f27f8, random_bits changed every 4 cycles -> text_out equals the SR(10,4,4,4) software model exactly 40 cycles after the start edge.
- Mask independence: same key/plaintext with t_mask=k_mask=0 and random_bits=0 -> identical ciphertext to the masked run.
- Randomness independence: random_bits held constant vs. new random_bits every cycle -> identical ciphertext.
- Busy and completion: pulse start again at cycle 10 -> ignored; text_out updates once at cycle 40. A back-to-back second start with new text_in -> the second result appears 40 cycles after its own start.
- Reset mid-run: rst low at cycle 20 -> text_out=0, no later update; a fresh start afterwards gives the correct result.
